mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4: number of requesting compute cores; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for read data before abort.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 core_req  in  NUM_CORES  per-core request, held high until that core's gnt is seen.
REQ-006 core_we  in  NUM_CORES  per-core write enable; 1 = write, 0 = read.
REQ-007 core_addr  in  64*NUM_CORES  per-core byte address; core i occupies bits [64i+63:64i].
REQ-008 core_wdata  in  64*NUM_CORES  per-core write data, same packing.
REQ-009 core_gnt  out  NUM_CORES  one-cycle completion pulse to the served core.
REQ-010 core_valid  out  NUM_CORES  one-cycle read-data-valid pulse, coincident with gnt, reads only.
REQ-011 core_rdata  out  64  shared read data, meaningful only while some core_valid bit is high.
REQ-012 m_req, m_we  out  1 each  downstream memory request and write enable.
REQ-013 m_addr, m_wdata  out  64 each  downstream address and write data.
REQ-014 m_ack  in  1  memory accepted the current request.
REQ-015 m_rvalid, m_rdata  in  1, 64  memory read-data return.
REQ-016 timeout_err  out  1  sticky flag, set on any read timeout.
REQ-017 grant_count  out  32  total completed transactions, wraps at 2^32.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_RD, RESP, COOL.
REQ-019 IDLE: if any core_req bit is set, select the winner by round-robin starting at index (last_winner+1) mod NUM_CORES, latch its we/addr/wdata and index, go to ISSUE; else stay.
REQ-020 ISSUE: m_req SHALL be 1 with the latched fields; on m_ack, drop m_req next cycle and go to WAIT_RD for a read or RESP for a write.
REQ-021 m_req SHALL remain asserted and all m_* fields SHALL remain stable from entry to ISSUE until m_ack is sampled.
REQ-022 WAIT_RD: on m_rvalid, latch m_rdata and go to RESP; count wait cycles, and when the count reaches TIMEOUT without m_rvalid, latch rdata = 0, set timeout_err, go to RESP.
REQ-023 m_rvalid in any state other than WAIT_RD SHALL be ignored.
REQ-024 RESP: pulse core_gnt[winner] for exactly one cycle, plus core_valid[winner] for reads, with core_rdata = latched data; increment grant_count; update last_winner = winner; go to COOL.
REQ-025 COOL: one idle cycle, during which the served core drops its request; then IDLE. A request is never granted twice.
REQ-026 Minimum latency, write: request sampled in IDLE at edge N, m_req high after edge N, m_ack at edge N+1 gives gnt high after edge N+2.
REQ-027 Minimum latency, read: request sampled in IDLE at edge N, m_ack at edge N+1, m_rvalid at edge N+2 gives gnt and valid high after edge N+3.
REQ-028 Round-robin SHALL guarantee that any continuously requesting core is served within NUM_CORES transactions.
REQ-029 core_req changes while the arbiter is not in IDLE SHALL affect only the next arbitration.
REQ-030 m_ack and m_rvalid arriving in the same cycle during ISSUE SHALL be treated as ack followed by immediate data: go directly to RESP.
REQ-031 At most one downstream transaction SHALL be outstanding at any time.

Reset
REQ-032 While rst_n = 0, asynchronously: state = IDLE, m_req = 0, m_we = 0, m_addr = 0, m_wdata = 0, core_gnt = 0, core_valid = 0, core_rdata = 0, timeout_err = 0, grant_count = 0, last_winner = NUM_CORES-1 (so core 0 wins first), wait counter = 0.
REQ-033 Reset asserted mid-transaction SHALL abandon that transaction without issuing gnt; after release, sampling restarts in IDLE.
REQ-034 timeout_err SHALL clear only on reset.

Verification
REQ-035 Core 2 alone writes addr 0xC8, data 0xDEADBEEF, with m_ack one cycle after m_req -> m_addr = 0xC8, core_gnt = 0b0100 for one cycle, core_valid = 0, grant_count = 1.
REQ-036 Core 1 reads addr 0x64 and memory returns 0x1234 two cycles after ack -> core_gnt[1] and core_valid[1] pulse together, core_rdata = 0x1234.
REQ-037 All 4 cores request continuously from reset -> grant order 0,1,2,3,0, each gnt exactly one cycle, no core granted twice per request.
REQ-038 Read with m_rvalid never returned -> after 255 wait cycles, gnt and valid pulse with core_rdata = 0, timeout_err = 1 and stays 1 through later transactions.
REQ-039 rst_n pulled low while in WAIT_RD -> all outputs 0 immediately; after release, the pending core re-requests and is served normally with grant_count = 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CORES requesters onto one
// downstream memory port, one transaction in flight at a time.
module mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [64*NUM_CORES-1:0] core_addr,
  input  logic [64*NUM_CORES-1:0] core_wdata,
  output logic [NUM_CORES-1:0]    core_gnt,
  output logic [NUM_CORES-1:0]    core_valid,
  output logic [63:0]             core_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [63:0]             m_addr,
  output logic [63:0]             m_wdata,
  input  logic                    m_ack,
  input  logic                    m_rvalid,
  input  logic [63:0]             m_rdata,
  output logic                    timeout_err,
  output logic [31:0]             grant_count
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_RD, RESP, COOL
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]        last_q, last_n;
  logic [IW-1:0]        win_q, win_n;
  logic [IW-1:0]        pick, cand;
  logic                 found;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [63:0]          rdata_q, rdata_n;
  logic                 m_req_n, m_we_n;
  logic [63:0]          m_addr_n, m_wdata_n;
  logic [NUM_CORES-1:0] gnt_n, valid_n;
  logic [63:0]          crdata_n;
  logic                 terr_n;
  logic [31:0]          gcount_n;

  // first requester at or after last_winner+1, wrapping
  always_comb begin
    pick  = last_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_CORES);
      if (!found && core_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    last_n    = last_q;
    win_n     = win_q;
    cnt_n     = cnt_q;
    rdata_n   = rdata_q;
    m_req_n   = m_req;
    m_we_n    = m_we;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
    gnt_n     = '0;
    valid_n   = '0;
    crdata_n  = '0;
    terr_n    = timeout_err;
    gcount_n  = grant_count;
    unique case (state)
      IDLE: begin
        if (found) begin
          win_n     = pick;
          m_req_n   = 1'b1;
          m_we_n    = core_we[pick];
          m_addr_n  = core_addr[int'(pick)*64 +: 64];
          m_wdata_n = core_wdata[int'(pick)*64 +: 64];
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ack) begin
          m_req_n = 1'b0;
          cnt_n   = '0;
          if (m_we) begin
            rdata_n = '0;
            state_n = RESP;
          end else if (m_rvalid) begin
            rdata_n = m_rdata;
            state_n = RESP;
          end else begin
            state_n = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (m_rvalid) begin
          rdata_n = m_rdata;
          state_n = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_n = '0;
          terr_n  = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      RESP: begin
        gnt_n[win_q]   = 1'b1;
        valid_n[win_q] = !m_we;
        crdata_n       = m_we ? 64'd0 : rdata_q;
        gcount_n       = grant_count + 32'd1;
        last_n         = win_q;
        state_n        = COOL;
      end
      COOL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_q      <= IW'(NUM_CORES - 1);
      win_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      core_gnt    <= '0;
      core_valid  <= '0;
      core_rdata  <= '0;
      timeout_err <= 1'b0;
      grant_count <= '0;
    end else begin
      state       <= state_n;
      last_q      <= last_n;
      win_q       <= win_n;
      cnt_q       <= cnt_n;
      rdata_q     <= rdata_n;
      m_req       <= m_req_n;
      m_we        <= m_we_n;
      m_addr      <= m_addr_n;
      m_wdata     <= m_wdata_n;
      core_gnt    <= gnt_n;
      core_valid  <= valid_n;
      core_rdata  <= crdata_n;
      timeout_err <= terr_n;
      grant_count <= gcount_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random request batches, a
// reactive memory model and a transaction-level reference model.
module tb_mem_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   core_req, core_we;
  logic [N-1:0]   core_gnt, core_valid;
  logic [64*N-1:0] core_addr, core_wdata;
  logic [63:0]    core_rdata;
  logic           m_req, m_we, m_ack, m_rvalid;
  logic [63:0]    m_addr, m_wdata, m_rdata;
  logic           timeout_err;
  logic [31:0]    grant_count;

  mem_arbiter #(.NUM_CORES(N), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_valid(core_valid),
    .core_rdata(core_rdata),
    .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .timeout_err(timeout_err), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          core;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    bit          tmo;
  } exp_t;

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mreq_t;

  exp_t  sbq[$];
  mreq_t mq[$];
  int    gnt_log[$];

  int total = 0;
  int bad   = 0;

  int model_last;
  int model_cnt;
  bit model_terr;
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] env_mem[logic [63:0]];

  int ack_min = 0, ack_max = 0;
  int rv_min = 0, rv_max = 0;
  bit mem_hold = 1'b0;
  int issue_cyc = 0;
  int last_gnt_cyc = 0;

  logic [63:0]  b_addr[N];
  logic [63:0]  b_wdata[N];
  logic [N-1:0] bwe, bmask;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A1234, ~a[31:0]};
  endfunction

  function automatic logic [63:0] env_rd(input logic [63:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  task automatic flush();
    sbq.delete();
    mq.delete();
    model_last = N - 1;
    model_cnt  = 0;
    model_terr = 1'b0;
    core_req   = '0;
  endtask

  // predicted service order is round-robin over the batch mask
  task automatic issue(input logic [N-1:0] mask,
                       input logic [N-1:0] we_v);
    exp_t  e;
    mreq_t r;
    int    c, start;
    @(negedge clk);
    start = model_last;
    for (int i = 1; i <= N; i++) begin
      c = (start + i) % N;
      if (mask[c]) begin
        e.core  = c;
        e.we    = we_v[c];
        e.addr  = b_addr[c];
        e.wdata = b_wdata[c];
        e.tmo   = 1'b0;
        e.rdata = '0;
        if (we_v[c])
          ref_mem[b_addr[c]] = b_wdata[c];
        else if (b_addr[c][15:0] == 16'hDEAD)
          e.tmo = 1'b1;
        else if (ref_mem.exists(b_addr[c]))
          e.rdata = ref_mem[b_addr[c]];
        else
          e.rdata = dflt(b_addr[c]);
        sbq.push_back(e);
        r.we    = we_v[c];
        r.addr  = b_addr[c];
        r.wdata = b_wdata[c];
        mq.push_back(r);
        model_last = c;
        core_we[c] = we_v[c];
        core_addr[64*c +: 64]  = b_addr[c];
        core_wdata[64*c +: 64] = b_wdata[c];
      end
    end
    core_req  = core_req | mask;
    issue_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (core_req != '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (core_req != '0) begin
      chk("batch_budget", core_req, '0);
      core_req = '0;
    end
  endtask

  // memory model: random ack/data delays, optional never-return
  initial begin
    mreq_t       r;
    logic [63:0] a, d;
    bit          w, nev;
    int          ad, rd;
    m_ack    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && m_req) begin
        w = m_we;
        a = m_addr;
        d = m_wdata;
        if (mq.size() == 0) begin
          chk("m_req_unexpected", 64'd1, 64'd0);
        end else begin
          r = mq.pop_front();
          chk("m_we", 64'(w), 64'(r.we));
          chk("m_addr", a, r.addr);
          if (r.we) chk("m_wdata", d, r.wdata);
        end
        ad = $urandom_range(ack_max, ack_min);
        repeat (ad) begin
          @(negedge clk);
          chk("m_stable", 64'(m_req && m_we == w &&
              m_addr == a && m_wdata == d), 64'd1);
        end
        m_ack = 1'b1;
        nev = mem_hold || (a[15:0] == 16'hDEAD);
        rd  = $urandom_range(rv_max, rv_min);
        if (w) begin
          env_mem[a] = d;
          m_rvalid = 1'($urandom_range(1, 0));
          m_rdata  = {$urandom, $urandom};
        end else if (!nev && rd == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = env_rd(a);
        end
        @(negedge clk);
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
        if (!w && !nev && rd > 0) begin
          repeat (rd - 1) @(negedge clk);
          m_rvalid = 1'b1;
          m_rdata  = env_rd(a);
          @(negedge clk);
          m_rvalid = 1'b0;
        end
        if (!nev) begin
          m_rvalid = 1'($urandom_range(1, 0));
          m_rdata  = {$urandom, $urandom};
          @(negedge clk);
          m_rvalid = 1'b0;
        end
      end
    end
  end

  exp_t         me;
  logic [N-1:0] eg;

  always @(negedge clk) begin
    if (rst_n && (core_gnt != '0 || core_valid != '0)) begin
      for (int i = 0; i < N; i++)
        if (core_gnt[i]) begin
          gnt_log.push_back(i);
          break;
        end
      if (sbq.size() == 0) begin
        chk("gnt_unexpected", 64'(core_gnt), 64'd0);
      end else begin
        me = sbq.pop_front();
        eg = N'(1) << me.core;
        chk("core_gnt", 64'(core_gnt), 64'(eg));
        chk("core_valid", 64'(core_valid),
            me.we ? 64'd0 : 64'(eg));
        if (!me.we) chk("core_rdata", core_rdata, me.rdata);
        model_cnt++;
        if (me.tmo) model_terr = 1'b1;
        chk("grant_count", 64'(grant_count), 64'(model_cnt));
        chk("timeout_err", 64'(timeout_err), 64'(model_terr));
        last_gnt_cyc = cyc;
      end
      core_req = core_req & ~core_gnt;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    flush();
    repeat (3) @(negedge clk);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_we", 64'(m_we), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_m_wdata", m_wdata, 64'd0);
    chk("rst_gnt", 64'(core_gnt), 64'd0);
    chk("rst_valid", 64'(core_valid), 64'd0);
    chk("rst_rdata", core_rdata, 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_count", 64'(grant_count), 64'd0);
    rst_n = 1'b1;

    // core 2 write, immediate ack
    b_addr[2]  = 64'hC8;
    b_wdata[2] = 64'hDEADBEEF;
    issue(4'b0100, 4'b0100);
    wait_done(50);
    chk("wr_latency", 64'(last_gnt_cyc - issue_cyc), 64'd3);

    // core 1 read, data two cycles after ack
    env_mem[64'h64] = 64'h1234;
    ref_mem[64'h64] = 64'h1234;
    rv_min    = 2;
    rv_max    = 2;
    b_addr[1] = 64'h64;
    issue(4'b0010, 4'b0000);
    wait_done(50);
    chk("rd_latency", 64'(last_gnt_cyc - issue_cyc), 64'd5);

    // read that never returns data
    b_addr[0] = 64'hDEAD;
    issue(4'b0001, 4'b0000);
    wait_done(400);
    chk("tmo_latency", 64'(last_gnt_cyc - issue_cyc), 64'd258);
    chk("tmo_flag", 64'(timeout_err), 64'd1);

    ack_max = 2;
    rv_min  = 0;
    rv_max  = 3;
    repeat (40) begin
      bmask = N'($urandom_range(15, 1));
      for (int i = 0; i < N; i++) begin
        bwe[i]     = 1'($urandom_range(1, 0));
        b_addr[i]  = 64'h100 + 64'(8 * $urandom_range(7, 0));
        b_wdata[i] = {$urandom, $urandom};
        if (!bwe[i] && $urandom_range(19, 0) == 0)
          b_addr[i] = 64'hDEAD;
      end
      issue(bmask, bwe);
      wait_done(3000);
    end
    chk("tmo_sticky", 64'(timeout_err), 64'd1);

    // reset while waiting for read data
    ack_max   = 0;
    mem_hold  = 1'b1;
    b_addr[1] = 64'h108;
    issue(4'b0010, 4'b0000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m_req", 64'(m_req), 64'd0);
    chk("mid_rst_m_addr", m_addr, 64'd0);
    chk("mid_rst_gnt", 64'(core_gnt), 64'd0);
    chk("mid_rst_valid", 64'(core_valid), 64'd0);
    chk("mid_rst_count", 64'(grant_count), 64'd0);
    chk("mid_rst_terr", 64'(timeout_err), 64'd0);
    flush();
    mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'b0010, 4'b0000);
    wait_done(100);
    chk("post_rst_count", 64'(grant_count), 64'd1);

    // all four cores from reset, twice
    @(negedge clk);
    rst_n = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    repeat (2) begin
      for (int i = 0; i < N; i++) begin
        bwe[i]     = 1'($urandom_range(1, 0));
        b_addr[i]  = 64'h100 + 64'(8 * $urandom_range(7, 0));
        b_wdata[i] = {$urandom, $urandom};
      end
      issue(4'hF, bwe);
      wait_done(3000);
    end
    chk("order_len", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      chk("rr_order", 64'(gnt_log[i]), 64'(i % N));

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("mq_empty", 64'(mq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
